defuzz_div: RTL and testbench

Sequential centroid defuzzifier sitting directly downstream of the 9-rule weighting stage. It accepts the rule-strength sum S_w (24-bit) and the weighted-gain sum S_wg (32-bit) and computes the crisp output S_wg / S_w with a multi-cycle restoring divider. It then saturates the quotient to Q1.15 and also delivers it as an integer percent for the actuator stage. Valid/ready handshakes on both sides decouple it from the combinational rule stage and from the consumer.

---
 rtl/defuzz_div.sv | 138 +++++++++++++
 tb/tb_defuzz_div.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/defuzz_div.sv
// Centroid defuzzifier: computes S_wg / S_w with a 32-step restoring divider,
// saturates the quotient to Q1.15 and also reports it as a rounded percent.
module defuzz_div #(
    parameter logic [15:0] DEFAULT_Q15 = 16'h0000,
    parameter logic [7:0]  DEFAULT_PCT = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] S_w,
    input  logic [31:0] S_wg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] u_q15,
    output logic [7:0]  u_pct,
    output logic        zero_w,
    output logic        sat
);

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [24:0] rem_q, rem_d;
    logic [23:0] dvs_q, dvs_d;
    logic [31:0] dq_q, dq_d;      // dividend shifts out the top, quotient shifts in the bottom
    logic [15:0] u_q15_q, u_q15_d;
    logic [7:0]  u_pct_q, u_pct_d;
    logic        zero_w_q, zero_w_d;
    logic        sat_q, sat_d;

    logic [24:0] rem_shift;
    logic [24:0] rem_sub;
    logic        q_bit;
    logic [31:0] q_next;
    logic        q_over;
    logic [15:0] q15_clamped;
    logic [22:0] pct_prod;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            dq_q     <= '0;
            u_q15_q  <= '0;
            u_pct_q  <= '0;
            zero_w_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            dq_q     <= dq_d;
            u_q15_q  <= u_q15_d;
            u_pct_q  <= u_pct_d;
            zero_w_q <= zero_w_d;
            sat_q    <= sat_d;
        end
    end

    // One restoring step plus the final saturation / percent conversion.
    always_comb begin
        rem_shift   = {rem_q[23:0], dq_q[31]};
        q_bit       = (rem_shift >= {1'b0, dvs_q});
        rem_sub     = q_bit ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
        q_next      = {dq_q[30:0], q_bit};
        q_over      = (q_next > 32'h0000_7FFF);
        q15_clamped = q_over ? 16'h7FFF : q_next[15:0];
        // 32767*100 + 16384 < 2^22, so 23 bits never overflow
        pct_prod    = 23'(q15_clamped) * 23'd100 + 23'd16384;
    end

    // Next-state logic: accept in idle, iterate, then hold until consumed.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        dq_d     = dq_q;
        u_q15_d  = u_q15_q;
        u_pct_d  = u_pct_q;
        zero_w_d = zero_w_q;
        sat_d    = sat_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    dvs_d   = S_w;
                    dq_d    = S_wg;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                // Zero divisor is caught on the first iteration cycle, so the
                // default result appears one cycle after accept.
                if (dvs_q == '0) begin
                    u_q15_d  = DEFAULT_Q15;
                    u_pct_d  = DEFAULT_PCT;
                    zero_w_d = 1'b1;
                    sat_d    = 1'b0;
                    state_d  = StDone;
                end else begin
                    rem_d = rem_sub;
                    dq_d  = q_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        u_q15_d  = q15_clamped;
                        u_pct_d  = pct_prod[22:15];
                        zero_w_d = 1'b0;
                        sat_d    = q_over;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign u_q15     = u_q15_q;
    assign u_pct     = u_pct_q;
    assign zero_w    = zero_w_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_defuzz_div.sv
// Self-checking bench for defuzz_div: directed cases plus randomized
// transactions against an arithmetic reference model.
module tb_defuzz_div;

    localparam logic [15:0] DefQ15 = 16'h1000;
    localparam logic [7:0]  DefPct = 8'd13;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] S_w;
    logic [31:0] S_wg;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] u_q15;
    logic [7:0]  u_pct;
    logic        zero_w;
    logic        sat;

    int passed = 0;
    int total  = 0;

    defuzz_div #(
        .DEFAULT_Q15(DefQ15),
        .DEFAULT_PCT(DefPct)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .S_w      (S_w),
        .S_wg     (S_wg),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .u_q15    (u_q15),
        .u_pct    (u_pct),
        .zero_w   (zero_w),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: floor divide, clamp to Q1.15, round-half-up percent.
    function automatic void model(input logic [23:0] sw, input logic [31:0] swg,
                                  output logic [15:0] q15, output logic [7:0] pct,
                                  output logic s, output logic z);
        longint unsigned q;
        longint unsigned p;
        if (sw == 24'd0) begin
            q15 = DefQ15;
            pct = DefPct;
            s   = 1'b0;
            z   = 1'b1;
        end else begin
            q   = longint'(swg) / longint'(sw);
            s   = (q > 64'd32767);
            q15 = s ? 16'h7FFF : 16'(q);
            p   = (longint'(q15) * 100 + 16384) / 32768;
            pct = 8'(p);
            z   = 1'b0;
        end
    endfunction

    // One full transaction; hold = cycles out_ready stays low after out_valid.
    task automatic run_txn(input logic [23:0] sw, input logic [31:0] swg, input int hold);
        logic [15:0] eq;
        logic [7:0]  ep;
        logic        es;
        logic        ez;
        int          cyc;
        model(sw, swg, eq, ep, es, ez);
        out_ready = (hold == 0);
        S_w       = sw;
        S_wg      = swg;
        in_valid  = 1'b1;
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        S_w      = 24'($urandom);
        S_wg     = $urandom;
        cyc      = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), ez ? 32'd1 : 32'd32);
        check("u_q15", 32'(u_q15), 32'(eq));
        check("u_pct", 32'(u_pct), 32'(ep));
        check("sat", 32'(sat), 32'(es));
        check("zero_w", 32'(zero_w), 32'(ez));
        check("no_overlap", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            S_w      = 24'($urandom);
            S_wg     = $urandom;
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_q15", 32'(u_q15), 32'(eq));
            check("bp_pct", 32'(u_pct), 32'(ep));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] rsw;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        S_w       = '0;
        S_wg      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_u_q15", 32'(u_q15), 32'd0);
        check("rst_u_pct", 32'(u_pct), 32'd0);
        check("rst_zero_w", 32'(zero_w), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);

        // Directed cases
        run_txn(24'd32767, 32'd536854528, 0);
        run_txn(24'd32768, 32'd536854528, 0);
        run_txn(24'd0, 32'h1234_5678, 0);
        run_txn(24'd1, 32'h0001_0000, 0);
        run_txn(24'd3, 32'd0, 0);
        run_txn(24'd32767, 32'd536854528, 10);

        // Reset mid-division, sampled at DIV step 10
        S_w      = 24'd7;
        S_wg     = 32'd100000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_u_q15", 32'(u_q15), 32'd0);
        check("midrst_u_pct", 32'(u_pct), 32'd0);
        check("midrst_sat_zero", {30'd0, sat, zero_w}, 32'd0);
        run_txn(24'd7, 32'd100000, 0);

        // Randomized transactions
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       rsw = 24'd0;
                1:       rsw = 24'($urandom_range(1, 255));
                default: rsw = 24'($urandom);
            endcase
            run_txn(rsw, $urandom, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
